kvs_resp_tx: RTL
================

Name: kvs_resp_tx

Overview:
Memcached binary-protocol response transmitter on the GMII TX side (gtx_clk domain). On a start pulse it latches the reply context and value length. It then emits one complete Ethernet/IPv4/UDP frame: preamble/SFD, headers, memcached UDP frame header, 24-byte response header, optional GET flags and value bytes streamed from the KVS value RAM, and the FCS. It is the response path for requests parsed by the kvs RX logic and replaces the fixed ARP test frame as the TX source.

Parameters:
SRC_MAC, 48'h00301ba0a48e, Ethernet source address
SRC_IP, 32'h0a00150a, IPv4 source address (10.0.21.10)
SRC_PORT, 16'd11211, UDP source port
MAX_VAL, 11'd1024, largest legal val_len; larger values are clamped to MAX_VAL

Ports:
gtx_clk  in  1  TX clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to send; honoured only in IDLE
busy  out  1  high from the cycle after an accepted start through the end of IFG
done  out  1  one-cycle pulse in the last IFG cycle
dst_mac  in  48  client MAC
dst_ip  in  32  client IP
dst_port  in  16  client UDP port
req_id  in  16  memcached UDP request id, echoed back
opcode  in  8  echoed opcode (8'h00 GET, 8'h01 SET)
status  in  16  response status
opaque  in  32  echoed opaque
val_len  in  11  value byte count V
val_base  in  17  RAM address of the first value byte
mem_address  out  17  registered value-RAM read address
mem_q  in  8  RAM data, valid one cycle after mem_address changes
tx_en  out  1  GMII transmit enable
txd  out  8  GMII transmit data

Behaviour:
- Reset values: busy=0, done=0, tx_en=0, txd=8'h00, mem_address=0; state=IDLE. Reset mid-frame aborts immediately; tx_en drops on the next edge and no FCS is sent.
- All inputs are sampled on the start cycle only. Later input changes have no effect.
- E = 4 when opcode==8'h00 and status==16'h0000; otherwise E = 0.
- Lengths: body_len = E+V. udp_len = 40+E+V. ip_len = 60+E+V. The frame is always at least 60 bytes, so there is no padding.
- States:
  - IDLE: on start -> CALC.
  - CALC (3 cycles): compute the IPv4 header checksum as the one's-complement of the 16-bit one's-complement sum of 4500, ip_len, 0000, 4000, 4011, SRC_IP hi/lo, dst_ip hi/lo, with end-around carries folded.
  - PRE: 7x 55 then D5.
  - HDR: bytes in network order:
    - dst_mac, SRC_MAC, 0800
    - 45 00, ip_len, 0000 (id), 4000 (DF), 40 (TTL), 11, checksum, SRC_IP, dst_ip
    - SRC_PORT, dst_port, udp_len, 0000 (UDP checksum)
    - req_id, 0000 (seq), 0001 (total), 0000
    - 81, opcode, 0000 (key len), E, 00, status, body_len as 32 bits, opaque, 8x 00 (CAS)
    - E bytes of 00 (flags)
  - VAL: V bytes from val_base..val_base+V-1. mem_address is issued one cycle ahead, so txd shows byte i in consecutive cycles with no bubbles. V=0 skips this state.
  - FCS: 4 bytes of IEEE 802.3 CRC-32 over dst_mac through the last value byte. CRC-32 is computed internally. A CRC over frame+FCS yields residue C704DD7B.
  - IFG: 12 cycles with tx_en=0; done pulses on the 12th cycle, then -> IDLE.
- Timing: start sampled at edge 0; first 55 appears with tx_en=1 at edge 4. tx_en stays high for exactly 86+E+V consecutive cycles. busy falls, and start is accepted again, in the cycle after done.
- start while busy is ignored, with no queueing.
- mem_address increments with 17-bit wrap-around from 1FFFF to 00000.
- txd is 00 whenever tx_en=0.

Test Plan:
1. SET response: opcode=01, status=0000, V=0, dst_ip=10.0.21.99 -> 86 tx_en cycles; ip_len=003C; IP checksum=FC44; udp_len=0028; body_len=0; FCS residue correct.
2. GET hit: opcode=00, status=0000, V=5, RAM[100..104]="hello", val_base=100 -> E=4 (flags 00000000) followed by "hello"; 95 tx_en cycles; body_len=00000009; ip_len=0045.
3. GET miss: status=0001, V=0 -> E=0 and extras length byte 00; 86 cycles; status bytes 00 01 at the correct offset.
4. start re-pulsed at frame cycles 10 and 50 -> ignored; one frame only; a start in the cycle after done is accepted.
5. sys_rst asserted mid-VAL -> next edge tx_en=0, busy=0, txd=00; a subsequent start sends a complete, correct frame.
6. V=MAX_VAL with val_base=1FFFE -> addresses wrap 1FFFE, 1FFFF, 00000...; 1110 tx_en cycles; no gaps in the value stream.

Source files
------------

// File: rtl/kvs_resp_tx.sv
// Memcached binary-protocol UDP response transmitter for the GMII TX side.
// One start pulse produces one complete Ethernet/IPv4/UDP reply frame, value bytes streamed from RAM.
module kvs_resp_tx #(
    parameter logic [47:0] SRC_MAC  = 48'h00301ba0a48e,
    parameter logic [31:0] SRC_IP   = 32'h0a00150a,
    parameter logic [15:0] SRC_PORT = 16'd11211,
    parameter logic [10:0] MAX_VAL  = 11'd1024
) (
    input  logic        gtx_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [15:0] req_id,
    input  logic [7:0]  opcode,
    input  logic [15:0] status,
    input  logic [31:0] opaque,
    input  logic [10:0] val_len,
    input  logic [16:0] val_base,
    output logic [16:0] mem_address,
    input  logic [7:0]  mem_q,
    output logic        tx_en,
    output logic [7:0]  txd
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PRE, S_HDR, S_VAL, S_FCS, S_IFG
    } state_e;

    state_e      state_q;
    logic [10:0] cnt_q;
    logic [47:0] dst_mac_q;
    logic [31:0] dst_ip_q;
    logic [15:0] dst_port_q;
    logic [15:0] req_id_q;
    logic [7:0]  opcode_q;
    logic [15:0] status_q;
    logic [31:0] opaque_q;
    logic        ext_q;
    logic [10:0] vlen_q;
    logic [19:0] sum_q;
    logic [15:0] csum_q;
    logic [31:0] crc_q;

    logic [10:0]  vlen_d;
    logic [15:0]  body_len;
    logic [15:0]  ip_len;
    logic [15:0]  udp_len;
    logic [19:0]  sum_d;
    logic [19:0]  fold_d;
    logic [7:0]   ext_byte;
    logic [10:0]  hdr_last;
    logic [591:0] hdr_vec;
    logic [6:0]   hdr_idx;
    logic [9:0]   hdr_bit;
    logic [7:0]   hdr_byte;
    logic [31:0]  fcs;
    logic [7:0]   fcs_byte;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign vlen_d   = (val_len > MAX_VAL) ? MAX_VAL : val_len;
    assign ext_byte = {5'd0, ext_q, 2'b00};
    assign body_len = {13'd0, ext_q, 2'b00} + {5'd0, vlen_q};
    assign ip_len   = body_len + 16'd60;
    assign udp_len  = body_len + 16'd40;
    assign hdr_last = ext_q ? 11'd77 : 11'd73;

    // IPv4 header sum; two folds are enough for nine 16-bit terms.
    assign sum_d  = 20'h04500 + {4'h0, ip_len} + 20'h04000 + 20'h04011
                  + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                  + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
    assign fold_d = {4'h0, sum_q[15:0]} + {16'h0, sum_q[19:16]};

    assign hdr_vec = {dst_mac_q, SRC_MAC, 16'h0800,
                      8'h45, 8'h00, ip_len, 16'h0000, 16'h4000, 8'h40, 8'h11, csum_q,
                      SRC_IP, dst_ip_q,
                      SRC_PORT, dst_port_q, udp_len, 16'h0000,
                      req_id_q, 16'h0000, 16'h0001, 16'h0000,
                      8'h81, opcode_q, 16'h0000, ext_byte, 8'h00, status_q,
                      {16'h0000, body_len}, opaque_q, 64'h0};

    // Header indices 74..77 are the GET flags word, always zero.
    assign hdr_idx = 7'd73 - cnt_q[6:0];
    assign hdr_bit = {hdr_idx, 3'b000};
    always_comb begin
        hdr_byte = 8'h00;
        if (cnt_q < 11'd74) hdr_byte = hdr_vec[hdr_bit +: 8];
    end

    assign fcs = ~crc_q;
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    always_ff @(posedge gtx_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_en       <= 1'b0;
            txd         <= 8'h00;
            mem_address <= '0;
            dst_mac_q   <= '0;
            dst_ip_q    <= '0;
            dst_port_q  <= '0;
            req_id_q    <= '0;
            opcode_q    <= '0;
            status_q    <= '0;
            opaque_q    <= '0;
            ext_q       <= 1'b0;
            vlen_q      <= '0;
            sum_q       <= '0;
            csum_q      <= '0;
            crc_q       <= 32'hFFFFFFFF;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    tx_en <= 1'b0;
                    txd   <= 8'h00;
                    if (start) begin
                        dst_mac_q   <= dst_mac;
                        dst_ip_q    <= dst_ip;
                        dst_port_q  <= dst_port;
                        req_id_q    <= req_id;
                        opcode_q    <= opcode;
                        status_q    <= status;
                        opaque_q    <= opaque;
                        ext_q       <= (opcode == 8'h00) && (status == 16'h0000);
                        vlen_q      <= vlen_d;
                        mem_address <= val_base;
                        crc_q       <= 32'hFFFFFFFF;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        state_q     <= S_CALC;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q == 11'd0) begin
                        sum_q <= sum_d;
                    end else if (cnt_q == 11'd1) begin
                        sum_q <= fold_d;
                    end else begin
                        csum_q  <= ~fold_d[15:0];
                        cnt_q   <= '0;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    tx_en <= 1'b1;
                    txd   <= (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q == 11'd7) begin
                        cnt_q   <= '0;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    txd   <= hdr_byte;
                    crc_q <= crc_byte(crc_q, hdr_byte);
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q == hdr_last) begin
                        cnt_q <= '0;
                        if (vlen_q == 11'd0) begin
                            state_q <= S_FCS;
                        end else begin
                            // RAM has two edges of latency to txd, so the address runs one byte ahead.
                            mem_address <= mem_address + 17'd1;
                            state_q     <= S_VAL;
                        end
                    end
                end
                S_VAL: begin
                    txd   <= mem_q;
                    crc_q <= crc_byte(crc_q, mem_q);
                    if (cnt_q == vlen_q - 11'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_FCS;
                    end else begin
                        cnt_q       <= cnt_q + 11'd1;
                        mem_address <= mem_address + 17'd1;
                    end
                end
                S_FCS: begin
                    txd   <= fcs_byte;
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q == 11'd3) begin
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end
                end
                S_IFG: begin
                    tx_en <= 1'b0;
                    txd   <= 8'h00;
                    cnt_q <= cnt_q + 11'd1;
                    done  <= (cnt_q == 11'd11);
                    if (cnt_q == 11'd12) begin
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
